fakeram_bist_ctrl: RTL and testbench
====================================

Name: fakeram_bist_ctrl

Overview:
- March C- built-in self-test initiator for the fakeram130 single-port SRAM macros (default 512x64).
- Drives the macro's request side (addr, we, wd, wmsk, ce) and checks the read data coming back. It is the requester counterpart to the RAM test wrapper.
- Sits between a test/config register block (start, status) and one fakeram instance. Compiled into test-chip tops only.

Parameters:
BITS, 64, data width of target RAM
ADDR_WIDTH, 9, address width; depth N = 2**ADDR_WIDTH
ERRCNT_WIDTH, 16, error counter width (used only with the optional feature)

Ports:
clk  input  1  single clock, shared with the RAM
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse to begin the test; ignored while busy_o=1
busy_o  output  1  test in progress
done_o  output  1  level; set at completion, cleared by next accepted start_i
fail_o  output  1  sticky miscompare flag; cleared by accepted start_i
fail_addr_o  output  ADDR_WIDTH  address of first miscompare
fail_phase_o  output  3  march element of first miscompare
addr_o  output  ADDR_WIDTH  RAM address
ce_o  output  1  RAM chip enable, active high
we_o  output  1  RAM write enable, active high
wd_o  output  BITS  RAM write data
wmsk_o  output  BITS  RAM write mask; all-ones whenever we_o=1
rd_i  input  BITS  RAM read data; valid the cycle after ce_o=1, we_o=0

Behaviour:
- Reset: busy_o, done_o, fail_o, ce_o, we_o = 0; addr_o, wd_o, wmsk_o, fail_addr_o, fail_phase_o = 0; FSM to IDLE.
- Reset asserted mid-test aborts immediately; no further RAM access.
- FSM states: IDLE -> RUN on start_i. RUN -> DRAIN after the last op of element 5. DRAIN -> DONE after one cycle. DONE -> RUN on start_i.
- March elements, with fail_phase_o encoding:
  - 0: up, W0
  - 1: up, R0 W1
  - 2: up, R1 W0
  - 3: down, R0 W1
  - 4: down, R1 W0
  - 5: down, R0
- "0" = all-zeros word; "1" = all-ones word.
- Up = addresses 0..N-1; down = N-1..0. The address counter reloads at each element boundary with no idle cycle.
- Two-op elements: read at address a, then write at address a on the next cycle, then advance the address. One op per cycle, ce_o=1 on every RUN cycle.
- Timing: if start_i is sampled at edge k, ops issue in cycles k+1 .. k+10N.
- Read check pipeline: each read registers an expected-value and address tag. rd_i is compared one cycle later. A mismatch on any bit is a failure.
- DRAIN performs the final compare with ce_o=0.
- In DONE: busy_o=0, done_o=1; visible in cycle k+10N+2.
- First failure latches fail_addr_o and fail_phase_o. Later failures never overwrite them.
- start_i in the same cycle as the final DRAIN compare is ignored; start_i is only accepted in IDLE or DONE.
- Accepting start_i clears done_o, fail_o, fail_addr_o and fail_phase_o.

Optional Feature:
FAKERAM_BIST_ERRCNT_EN
- Defined:
  - Adds output err_cnt_o [ERRCNT_WIDTH-1:0], reset 0 and cleared on accepted start_i.
  - Increments on every miscompare and saturates at all-ones.
  - The test always runs to completion (10N ops).
- Undefined:
  - No err_cnt_o port.
  - On the first miscompare the FSM goes straight to DONE on the next edge (done_o=1, fail_o=1).
  - An op issued in the detection cycle is allowed; none are issued after it.

Decomposition:
- Package fakeram_bist_pkg holds:
  - typedef march_phase_e (3-bit enum, values 0-5 as above)
  - typedef bist_state_e (IDLE, RUN, DRAIN, DONE)
  - localparam table of per-element direction and op sequence
- One natural sub-module: fakeram_bist_cmp (registered expected/tag pipeline, compare, first-fail capture, optional error counter).
- The address/phase sequencer stays in the top.

Test Plan:
- Good RAM behavioural model (1-cycle read), N=512, start pulse -> 5120 ce_o cycles; done_o at k+5122; fail_o=0; busy_o low the same cycle.
- Stuck-at-1 on bit 7 at address 0x1A3 -> fail_o=1, fail_addr_o=0x1A3, fail_phase_o=1.
  - With _EN: err_cnt_o=3, from the R0 reads in elements 1, 3 and 5.
  - Without _EN: done_o rises 2 cycles after the failing read issue.
- Ordering check on the bus: element 3 first access addr_o=0x1FF, we_o=0, then 0x1FF with we_o=1, wd_o=all-ones, wmsk_o=all-ones.
- rst_n pulsed low mid element 2 -> ce_o=0 immediately, all outputs at reset values; a new start reruns from element 0 at address 0.
- start_i asserted while busy -> ignored, total length unchanged. start_i in DONE -> done_o and fail_o clear, new run begins.
- With _EN, all words read inverted -> err_cnt_o=5N=2560 (below saturation). With ERRCNT_WIDTH=8 -> err_cnt_o=255.

Source files
------------

// File: rtl/fakeram_bist_pkg.sv
// Shared types and the March C- element table for the fakeram BIST initiator.
// Optional feature macro used by the design: FAKERAM_BIST_ERRCNT_EN.
package fakeram_bist_pkg;

    typedef enum logic [2:0] {
        PH_W0_UP   = 3'd0,
        PH_R0W1_UP = 3'd1,
        PH_R1W0_UP = 3'd2,
        PH_R0W1_DN = 3'd3,
        PH_R1W0_DN = 3'd4,
        PH_R0_DN   = 3'd5
    } march_phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // down: address direction; rd/wr flags say which ops the element has, *_val is the data bit
    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } march_elem_t;

    localparam int NUM_ELEMS = 6;

    localparam march_elem_t MARCH_TBL [NUM_ELEMS] = '{
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
    };

    function automatic march_elem_t elem_of(input march_phase_e ph);
        march_elem_t e;
        case (ph)
            PH_W0_UP:   e = MARCH_TBL[0];
            PH_R0W1_UP: e = MARCH_TBL[1];
            PH_R1W0_UP: e = MARCH_TBL[2];
            PH_R0W1_DN: e = MARCH_TBL[3];
            PH_R1W0_DN: e = MARCH_TBL[4];
            PH_R0_DN:   e = MARCH_TBL[5];
            default:    e = MARCH_TBL[0];
        endcase
        return e;
    endfunction

    function automatic march_phase_e next_phase(input march_phase_e ph);
        march_phase_e n;
        case (ph)
            PH_W0_UP:   n = PH_R0W1_UP;
            PH_R0W1_UP: n = PH_R1W0_UP;
            PH_R1W0_UP: n = PH_R0W1_DN;
            PH_R0W1_DN: n = PH_R1W0_DN;
            PH_R1W0_DN: n = PH_R0_DN;
            default:    n = PH_W0_UP;
        endcase
        return n;
    endfunction

    // In a read-then-write element the second sub-op is the write
    function automatic logic op_is_write(input march_elem_t e, input logic sub);
        return e.has_wr && (!e.has_rd || sub);
    endfunction

endpackage

// File: rtl/fakeram_bist_cmp.sv
// Read-check pipeline: registers expected word and tag per read, compares rd one cycle later,
// captures the first failure. FAKERAM_BIST_ERRCNT_EN adds a saturating miscompare counter.
module fakeram_bist_cmp
    import fakeram_bist_pkg::*;
#(
    parameter int BITS         = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_rd_issue,
    input  logic                    i_exp_bit,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  march_phase_e            i_phase,
    input  logic [BITS-1:0]         i_rd,
`ifdef FAKERAM_BIST_ERRCNT_EN
    output logic [ERRCNT_WIDTH-1:0] o_err_cnt,
`else
    output logic                    o_mis,
`endif
    output logic                    o_fail,
    output logic [ADDR_WIDTH-1:0]   o_fail_addr,
    output march_phase_e            o_fail_phase
);

    logic                  r_vld;
    logic [BITS-1:0]       r_exp;
    logic [ADDR_WIDTH-1:0] r_tag_addr;
    march_phase_e          r_tag_phase;
    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    march_phase_e          r_fail_phase;
    logic                  w_mis;

    assign w_mis = r_vld && (i_rd != r_exp);

    // Expected-value and tag stage for the read currently on the RAM bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= 1'b0;
            r_exp       <= {BITS{1'b0}};
            r_tag_addr  <= {ADDR_WIDTH{1'b0}};
            r_tag_phase <= PH_W0_UP;
        end else if (i_clr) begin
            r_vld       <= 1'b0;
        end else begin
            r_vld <= i_rd_issue;
            if (i_rd_issue) begin
                r_exp       <= {BITS{i_exp_bit}};
                r_tag_addr  <= i_addr;
                r_tag_phase <= i_phase;
            end
        end
    end

    // Sticky first-failure capture; later miscompares leave the record alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= {ADDR_WIDTH{1'b0}};
            r_fail_phase <= PH_W0_UP;
        end else if (i_clr) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= {ADDR_WIDTH{1'b0}};
            r_fail_phase <= PH_W0_UP;
        end else if (w_mis && !r_fail) begin
            r_fail       <= 1'b1;
            r_fail_addr  <= r_tag_addr;
            r_fail_phase <= r_tag_phase;
        end
    end

    assign o_fail       = r_fail;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_phase = r_fail_phase;

`ifdef FAKERAM_BIST_ERRCNT_EN
    localparam logic [ERRCNT_WIDTH-1:0] CNT_MAX = {ERRCNT_WIDTH{1'b1}};
    localparam logic [ERRCNT_WIDTH-1:0] CNT_ONE = {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
    logic [ERRCNT_WIDTH-1:0] r_err_cnt;

    // Saturating miscompare counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= {ERRCNT_WIDTH{1'b0}};
        end else if (i_clr) begin
            r_err_cnt <= {ERRCNT_WIDTH{1'b0}};
        end else if (w_mis && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_mis = w_mis;
`endif

endmodule

// File: rtl/fakeram_bist_ctrl.sv
// March C- BIST initiator for a fakeram130 single-port macro: sequencer, FSM and RAM request bus.
// FAKERAM_BIST_ERRCNT_EN: count every miscompare and always run to completion.
module fakeram_bist_ctrl
    import fakeram_bist_pkg::*;
#(
    parameter int BITS         = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    fail_o,
    output logic [ADDR_WIDTH-1:0]   fail_addr_o,
    output logic [2:0]              fail_phase_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    ce_o,
    output logic                    we_o,
    output logic [BITS-1:0]         wd_o,
    output logic [BITS-1:0]         wmsk_o,
`ifdef FAKERAM_BIST_ERRCNT_EN
    output logic [ERRCNT_WIDTH-1:0] err_cnt_o,
`endif
    input  logic [BITS-1:0]         rd_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    bist_state_e           r_state, w_state_nxt;
    march_phase_e          r_phase, w_phase_nxt;
    logic                  r_sub, w_sub_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic                  r_ce, r_we, r_busy, r_done;
    logic [BITS-1:0]       r_wd, r_wmsk;
    logic                  w_issue, w_we_nxt, w_start_acc, w_last_addr;
    logic                  w_rd_issue, w_exp_bit;
    march_elem_t           w_cur, w_nxt;
    march_phase_e          w_fail_phase;
`ifndef FAKERAM_BIST_ERRCNT_EN
    logic                  w_mis;
`endif

    // Next state and next RAM op; r_phase/r_sub/r_addr always describe the op on the bus
    always_comb begin
        w_start_acc = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_cur       = elem_of(r_phase);
        w_last_addr = w_cur.down ? (r_addr == ADDR_ZERO) : (r_addr == ADDR_LAST);
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_sub_nxt   = r_sub;
        w_addr_nxt  = r_addr;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = PH_W0_UP;
                    w_sub_nxt   = 1'b0;
                    w_addr_nxt  = ADDR_ZERO;
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
`ifndef FAKERAM_BIST_ERRCNT_EN
                if (w_mis) begin
                    w_state_nxt = ST_DONE;
                end else
`endif
                if (w_cur.has_rd && w_cur.has_wr && !r_sub) begin
                    w_sub_nxt = 1'b1;
                    w_issue   = 1'b1;
                end else if (!w_last_addr) begin
                    w_sub_nxt  = 1'b0;
                    w_addr_nxt = w_cur.down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
                    w_issue    = 1'b1;
                end else if (r_phase == PH_R0_DN) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    // element boundary: reload the counter with no idle cycle
                    w_phase_nxt = next_phase(r_phase);
                    w_sub_nxt   = 1'b0;
                    w_addr_nxt  = elem_of(next_phase(r_phase)).down ? ADDR_LAST : ADDR_ZERO;
                    w_issue     = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_nxt    = elem_of(w_phase_nxt);
        w_we_nxt = w_issue && op_is_write(w_nxt, w_sub_nxt);
    end

    // State, sequencer and registered RAM request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= PH_W0_UP;
            r_sub   <= 1'b0;
            r_addr  <= ADDR_ZERO;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_wd    <= {BITS{1'b0}};
            r_wmsk  <= {BITS{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_sub   <= w_sub_nxt;
            r_addr  <= w_addr_nxt;
            r_ce    <= w_issue;
            r_we    <= w_we_nxt;
            r_wd    <= w_we_nxt ? {BITS{w_nxt.wr_val}} : {BITS{1'b0}};
            r_wmsk  <= w_we_nxt ? {BITS{1'b1}} : {BITS{1'b0}};
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign w_rd_issue = r_ce && !r_we;
    assign w_exp_bit  = w_cur.rd_val;

    fakeram_bist_cmp #(
        .BITS         (BITS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .ERRCNT_WIDTH (ERRCNT_WIDTH)
    ) u_cmp (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_start_acc),
        .i_rd_issue   (w_rd_issue),
        .i_exp_bit    (w_exp_bit),
        .i_addr       (r_addr),
        .i_phase      (r_phase),
        .i_rd         (rd_i),
`ifdef FAKERAM_BIST_ERRCNT_EN
        .o_err_cnt    (err_cnt_o),
`else
        .o_mis        (w_mis),
`endif
        .o_fail       (fail_o),
        .o_fail_addr  (fail_addr_o),
        .o_fail_phase (w_fail_phase)
    );

    assign fail_phase_o = w_fail_phase;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign addr_o       = r_addr;
    assign ce_o         = r_ce;
    assign we_o         = r_we;
    assign wd_o         = r_wd;
    assign wmsk_o       = r_wmsk;

endmodule

// File: tb/tb_fakeram_bist_ctrl.sv
// Self-checking bench for fakeram_bist_ctrl: behavioural RAM with injectable faults and a
// March C- reference that lists every expected op. Honours FAKERAM_BIST_ERRCNT_EN.
module tb_fakeram_bist_ctrl;

    localparam int N     = 512;
    localparam int TOTAL = 10 * N;
    localparam logic [63:0] ONES = {64{1'b1}};
`ifdef FAKERAM_BIST_ERRCNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk, rst_n, start_i;
    logic        busy_o, done_o, fail_o, ce_o, we_o;
    logic [8:0]  fail_addr_o, addr_o;
    logic [2:0]  fail_phase_o;
    logic [63:0] wd_o, wmsk_o, rd_i;
`ifdef FAKERAM_BIST_ERRCNT_EN
    logic [15:0] err_cnt_o;
    logic [7:0]  err8;
    logic        b8, d8, f8, ce8, we8;
    logic [8:0]  fa8, a8;
    logic [2:0]  fp8;
    logic [63:0] wd8, wm8;
`endif

    int n_chk = 0;
    int n_bad = 0;

    fakeram_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .fail_addr_o(fail_addr_o), .fail_phase_o(fail_phase_o),
        .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .wd_o(wd_o), .wmsk_o(wmsk_o),
`ifdef FAKERAM_BIST_ERRCNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .rd_i(rd_i)
    );

`ifdef FAKERAM_BIST_ERRCNT_EN
    // Narrow-counter twin; it runs in lockstep so it can share the RAM read data
    fakeram_bist_ctrl #(.ERRCNT_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(b8), .done_o(d8),
        .fail_o(f8), .fail_addr_o(fa8), .fail_phase_o(fp8),
        .addr_o(a8), .ce_o(ce8), .we_o(we8), .wd_o(wd8), .wmsk_o(wm8),
        .err_cnt_o(err8), .rd_i(rd_i)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault model: 0 none, 1 single stuck bit, 2 every read inverted
    int          flt_mode = 0;
    logic [8:0]  flt_addr = 9'd0;
    int          flt_bit  = 0;
    logic        flt_val  = 1'b0;
    logic [63:0] mem [N];

    function automatic logic [63:0] ram_read(input logic [8:0] a, input logic [63:0] v);
        logic [63:0] r;
        r = v;
        if (flt_mode == 1 && a == flt_addr) r[flt_bit] = flt_val;
        else if (flt_mode == 2) r = ~v;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ce_o) begin
            if (we_o) mem[addr_o] <= (mem[addr_o] & ~wmsk_o) | (wd_o & wmsk_o);
            else      rd_i <= ram_read(addr_o, mem[addr_o]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [63:0] data;
        logic [2:0]  ph;
    } op_t;

    op_t ops[$];
    int  el_down [6] = '{0, 0, 0, 1, 1, 1};
    int  el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int  el_wr   [6] = '{0, 1, 0, 1, 0, -1};
    int  ref_first, ref_errs, ref_ops, ref_done;
    logic [8:0] ref_faddr;
    logic [2:0] ref_fph;

    task automatic build_ref();
        logic [63:0] rmem [N];
        logic [63:0] got;
        ops.delete();
        ref_first = -1; ref_errs = 0; ref_faddr = 9'd0; ref_fph = 3'd0;
        for (int a = 0; a < N; a++) rmem[a] = 64'd0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                int a;
                a = (el_down[e] != 0) ? (N - 1 - j) : j;
                if (el_rd[e] >= 0) ops.push_back('{1'b0, a[8:0], (el_rd[e] != 0) ? ONES : 64'd0, e[2:0]});
                if (el_wr[e] >= 0) ops.push_back('{1'b1, a[8:0], (el_wr[e] != 0) ? ONES : 64'd0, e[2:0]});
            end
        end
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i].we) begin
                rmem[ops[i].addr] = ops[i].data;
            end else begin
                got = ram_read(ops[i].addr, rmem[ops[i].addr]);
                if (got !== ops[i].data) begin
                    ref_errs++;
                    if (ref_first < 0) begin
                        ref_first = i; ref_faddr = ops[i].addr; ref_fph = ops[i].ph;
                    end
                end
            end
        end
        if (EN || ref_first < 0) begin
            ref_ops  = TOTAL;
            ref_done = TOTAL + 2;
        end else begin
            ref_ops  = (ref_first + 2 < TOTAL) ? ref_first + 2 : TOTAL;
            ref_done = ref_first + 3;
        end
    endtask

    // poke: 0 none, 1 start pulse mid-run, 2 start pulse in the final-compare cycle
    task automatic run_test(input string tag, input int poke);
        int done_at, bus_bad, ce_cnt, poke_n;
        logic [9:0]  e3a, e3b;
        logic [63:0] e3wd, e3m;
        logic [138:0] got, want;
        op_t op;
        build_ref();
        poke_n = (poke == 0) ? -100 : ((poke == 1) ? int'($urandom_range(2, ref_done - 2)) : ref_done - 1);
        done_at = -1; bus_bad = 0; ce_cnt = 0;
        e3a = 10'd0; e3b = 10'd0; e3wd = 64'd0; e3m = 64'd0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int n = 1; n <= TOTAL + 20; n++) begin
            if (n == 1) check({tag, "/start"}, {61'd0, busy_o, done_o, fail_o}, 64'd4);
            if (ce_o) ce_cnt++;
            if (n <= ref_ops) begin
                op   = ops[n - 1];
                want = {1'b1, op.we, op.addr, op.we ? op.data : 64'd0, op.we ? ONES : 64'd0};
                got  = {ce_o, we_o, addr_o, wd_o, wmsk_o};
                if (got !== want) bus_bad++;
            end else if ({ce_o, we_o} !== 2'b00) begin
                bus_bad++;
            end
            if (n == 5 * N + 1) e3a = {we_o, addr_o};
            if (n == 5 * N + 2) begin e3b = {we_o, addr_o}; e3wd = wd_o; e3m = wmsk_o; end
            if (done_o && done_at < 0) begin
                done_at = n;
                check({tag, "/busy_at_done"}, {63'd0, busy_o}, 64'd0);
            end else if (done_at >= 0 && (!done_o || busy_o)) begin
                bus_bad++;
            end
            if (done_at >= 0 && n >= done_at + 3) break;
            start_i = (n == poke_n);
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, "/done_cycle"}, 64'(done_at), 64'(ref_done));
        check({tag, "/ce_cycles"}, 64'(ce_cnt), 64'(ref_ops));
        check({tag, "/bus_errs"}, 64'(bus_bad), 64'd0);
        check({tag, "/fail"}, {63'd0, fail_o}, {63'd0, ref_first >= 0});
        check({tag, "/fail_addr"}, {55'd0, fail_addr_o}, {55'd0, ref_faddr});
        check({tag, "/fail_phase"}, {61'd0, fail_phase_o}, {61'd0, ref_fph});
`ifdef FAKERAM_BIST_ERRCNT_EN
        check({tag, "/err_cnt"}, {48'd0, err_cnt_o}, 64'((ref_errs > 65535) ? 65535 : ref_errs));
        check({tag, "/err_cnt8"}, {56'd0, err8}, 64'((ref_errs > 255) ? 255 : ref_errs));
`endif
        if (ref_ops >= 5 * N + 2) begin
            check({tag, "/e3_first"}, {54'd0, e3a}, {54'd0, 10'h1FF});
            check({tag, "/e3_second"}, {54'd0, e3b}, {54'd0, 10'h3FF});
            check({tag, "/e3_wd"}, e3wd, ONES);
            check({tag, "/e3_wmsk"}, e3m, ONES);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/flags"}, {59'd0, busy_o, done_o, fail_o, ce_o, we_o}, 64'd0);
        check({tag, "/addrs"}, {43'd0, addr_o, fail_addr_o, fail_phase_o}, 64'd0);
        check({tag, "/wd"}, wd_o, 64'd0);
        check({tag, "/wmsk"}, wmsk_o, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0;
        for (int a = 0; a < N; a++) mem[a] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        flt_mode = 0;
        run_test("good", 0);

        flt_mode = 1; flt_addr = 9'h1A3; flt_bit = 7; flt_val = 1'b1;
        run_test("sa1_b7_1a3", 1);

        flt_mode = 0;
        run_test("good_from_done", 2);

        // abort inside element 2, then a fresh run must restart at element 0, address 0
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (3 * N + 37) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check("rst_mid/ce_held", {63'd0, ce_o}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_test("after_rst", 0);

        flt_mode = 2;
        run_test("invert_all", 0);

        for (int r = 0; r < 4; r++) begin
            flt_mode = int'($urandom_range(0, 2));
            flt_addr = 9'($urandom_range(0, N - 1));
            flt_bit  = int'($urandom_range(0, 63));
            flt_val  = 1'($urandom_range(0, 1));
            run_test($sformatf("rnd%0d_m%0d", r, flt_mode), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
